// File: rtl/ntt4_seq_ctrl.sv
// 4-point sequential NTT: load four coefficients, run four in-place butterflies on one shared unit, stream results in natural order.
// Define NTT_SEQ_BF_PIPE_EN to register the modular product, which makes each butterfly op take two cycles.
module ntt4_seq_ctrl #(
  parameter logic [15:0] Q    = 16'd7681,
  parameter logic [15:0] PHI1 = 16'd1925,
  parameter logic [15:0] PHI2 = 16'd3383,
  parameter logic [15:0] PHI3 = 16'd6468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  load_idx_q, load_idx_d;
  logic [1:0]  op_idx_q, op_idx_d;
  logic [1:0]  out_idx_q, out_idx_d;
  logic [15:0] r_q [4];
  logic [15:0] r_d [4];

  logic [1:0]  sel_a, sel_b;
  logic [15:0] bf_a, bf_b, bf_w, bf_t, bf_up, bf_dn;
  logic [15:0] mul_t;
  logic [31:0] prod;
  logic [16:0] sum, diff;
  logic        wb_en;

  // Fixed op schedule: stage 1 pairs (r0,r2),(r1,r3); stage 2 pairs (r0,r1),(r2,r3).
  always_comb begin
    sel_a = 2'd0;
    sel_b = 2'd2;
    bf_w  = PHI2;
    case (op_idx_q)
      2'd0: begin sel_a = 2'd0; sel_b = 2'd2; bf_w = PHI2; end
      2'd1: begin sel_a = 2'd1; sel_b = 2'd3; bf_w = PHI2; end
      2'd2: begin sel_a = 2'd0; sel_b = 2'd1; bf_w = PHI1; end
      default: begin sel_a = 2'd2; sel_b = 2'd3; bf_w = PHI3; end
    endcase
  end

  always_comb begin
    bf_a  = r_q[sel_a];
    bf_b  = r_q[sel_b];
    prod  = {16'd0, bf_b} * {16'd0, bf_w};
    mul_t = 16'(prod % {16'd0, Q});
  end

`ifdef NTT_SEQ_BF_PIPE_EN
  logic [15:0] t_q, t_d;
  logic        phase_q, phase_d;

  // Phase 0 issues the multiply into t_q; phase 1 writes the butterfly back.
  always_comb begin
    t_d   = mul_t;
    bf_t  = t_q;
    wb_en = (state_q == CALC) && phase_q;
    phase_d = 1'b0;
    if (state_q == CALC) begin
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q     <= '0;
      phase_q <= 1'b0;
    end else begin
      t_q     <= t_d;
      phase_q <= phase_d;
    end
  end
`else
  always_comb begin
    bf_t  = mul_t;
    wb_en = (state_q == CALC);
  end
`endif

  // Modular add/sub on a 17-bit intermediate keeps both results below Q.
  always_comb begin
    sum = {1'b0, bf_a} + {1'b0, bf_t};
    if (sum >= {1'b0, Q}) begin
      bf_up = 16'(sum - {1'b0, Q});
    end else begin
      bf_up = sum[15:0];
    end
    if (bf_a < bf_t) begin
      diff = {1'b0, bf_a} + {1'b0, Q} - {1'b0, bf_t};
    end else begin
      diff = {1'b0, bf_a} - {1'b0, bf_t};
    end
    bf_dn = diff[15:0];
  end

  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    op_idx_d   = op_idx_q;
    out_idx_d  = out_idx_q;
    r_d        = r_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    busy       = 1'b0;

    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          r_d[load_idx_q] = in_data;
          load_idx_d      = load_idx_q + 2'd1;
          if (load_idx_q == 2'd3) begin
            state_d  = CALC;
            op_idx_d = 2'd0;
          end
        end
      end
      CALC: begin
        busy = 1'b1;
        if (wb_en) begin
          r_d[sel_a] = bf_up;
          r_d[sel_b] = bf_dn;
          op_idx_d   = op_idx_q + 2'd1;
          if (op_idx_q == 2'd3) begin
            state_d   = OUT;
            out_idx_d = 2'd0;
          end
        end
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // Bit-reversed read order turns the in-place result into natural order.
        out_data  = r_q[{out_idx_q[0], out_idx_q[1]}];
        if (out_ready) begin
          out_idx_d = out_idx_q + 2'd1;
          if (out_idx_q == 2'd3) begin
            state_d    = LOAD;
            load_idx_d = 2'd0;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      load_idx_q <= '0;
      op_idx_q   <= '0;
      out_idx_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      load_idx_q <= load_idx_d;
      op_idx_q   <= op_idx_d;
      out_idx_q  <= out_idx_d;
      r_q        <= r_d;
    end
  end

endmodule
